// File: rtl/parc_fetch_unit.sv
`timescale 1ns/1ps
// parc_fetch_unit: instruction fetch stage with a 2-entry in-order buffer.
// Requests are issued at fetch_pc; responses return in order. live_cnt tracks
// requests on the current path, drop_cnt tracks requests whose responses must
// be discarded because a redirect squashed their path.
module parc_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_val,
  input  logic [31:0] redirect_pc,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_msg_addr,
  input  logic        imemresp_val,
  input  logic [31:0] imemresp_msg_data,
  output logic        inst_val_Dhl,
  output logic [31:0] inst_Dhl,
  output logic [31:0] pc_Dhl,
  input  logic        inst_rdy_Dhl
);

  localparam logic [31:0] RESET_VECTOR = 32'h00080000;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  live_cnt_q, live_cnt_d;
  logic [1:0]  drop_cnt_q, drop_cnt_d;
  logic [1:0]  buf_cnt_q,  buf_cnt_d;
  logic [31:0] head_pc_q,  head_pc_d;
  logic [31:0] head_inst_q, head_inst_d;
  logic [31:0] tail_pc_q,  tail_pc_d;
  logic [31:0] tail_inst_q, tail_inst_d;

  logic [2:0]  live_plus_buf;
  logic [2:0]  live_plus_drop;
  logic        fire;
  logic        deq;
  logic        keep_resp;
  logic        drop_resp;
  logic [31:0] resp_pc;
  logic [1:0]  cnt_after_deq;

  assign live_plus_buf  = {1'b0, live_cnt_q} + {1'b0, buf_cnt_q};
  assign live_plus_drop = {1'b0, live_cnt_q} + {1'b0, drop_cnt_q};

  // Throttle so that every live request is guaranteed a buffer slot and the
  // total outstanding count fits the drop counter.
  assign imemreq_val = !reset && !redirect_val &&
                       (live_plus_buf < 3'd2) && (live_plus_drop < 3'd3);
  assign imemreq_msg_addr = fetch_pc_q;
  assign fire = imemreq_val && imemreq_rdy;

  assign inst_val_Dhl = (buf_cnt_q != 2'd0);
  assign inst_Dhl     = head_inst_q;
  assign pc_Dhl       = head_pc_q;
  assign deq          = inst_val_Dhl && inst_rdy_Dhl;

  assign keep_resp = imemresp_val && !redirect_val && (drop_cnt_q == 2'd0);
  assign drop_resp = imemresp_val && !redirect_val && (drop_cnt_q != 2'd0);

  // Oldest live request was issued live_cnt words behind the current fetch_pc.
  assign resp_pc = fetch_pc_q - {28'd0, live_cnt_q, 2'b00};
  assign cnt_after_deq = deq ? (buf_cnt_q - 2'd1) : buf_cnt_q;

  // Next-state: redirect squashes everything; otherwise issue, retire, enqueue.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    live_cnt_d  = live_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    buf_cnt_d   = buf_cnt_q;
    head_pc_d   = head_pc_q;
    head_inst_d = head_inst_q;
    tail_pc_d   = tail_pc_q;
    tail_inst_d = tail_inst_q;
    if (redirect_val) begin
      fetch_pc_d = redirect_pc;
      buf_cnt_d  = 2'd0;
      live_cnt_d = 2'd0;
      drop_cnt_d = drop_cnt_q + live_cnt_q - {1'b0, imemresp_val};
    end else begin
      if (fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      live_cnt_d = live_cnt_q + {1'b0, fire} - {1'b0, keep_resp};
      if (drop_resp) begin
        drop_cnt_d = drop_cnt_q - 2'd1;
      end
      if (deq) begin
        head_pc_d   = tail_pc_q;
        head_inst_d = tail_inst_q;
      end
      if (keep_resp) begin
        if (cnt_after_deq == 2'd0) begin
          head_pc_d   = resp_pc;
          head_inst_d = imemresp_msg_data;
        end else begin
          tail_pc_d   = resp_pc;
          tail_inst_d = imemresp_msg_data;
        end
      end
      buf_cnt_d = cnt_after_deq + {1'b0, keep_resp};
    end
  end

  // State registers; buffer payload needs no reset since buf_cnt qualifies it.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_VECTOR;
      live_cnt_q <= 2'd0;
      drop_cnt_q <= 2'd0;
      buf_cnt_q  <= 2'd0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      live_cnt_q  <= live_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      buf_cnt_q   <= buf_cnt_d;
      head_pc_q   <= head_pc_d;
      head_inst_q <= head_inst_d;
      tail_pc_q   <= tail_pc_d;
      tail_inst_q <= tail_inst_d;
    end
  end

  // A kept response must always find room once any same-cycle dequeue is done.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(keep_resp && !deq && (buf_cnt_q == 2'd2)));

endmodule

// File: tb/tb_parc_fetch_unit.sv
`timescale 1ns/1ps
// Randomized bench for parc_fetch_unit. The reference keeps the memory's
// in-flight requests in a queue tagged with a path epoch, and the decode
// buffer as a queue of {pc, inst}; outputs are compared every cycle.
module tb_parc_fetch_unit;

  localparam logic [31:0] RV = 32'h00080000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_val;
  logic [31:0] redirect_pc;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_msg_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_msg_data;
  logic        inst_val_Dhl;
  logic [31:0] inst_Dhl;
  logic [31:0] pc_Dhl;
  logic        inst_rdy_Dhl;

  always #5 clk = ~clk;

  parc_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .redirect_val      (redirect_val),
    .redirect_pc       (redirect_pc),
    .imemreq_val       (imemreq_val),
    .imemreq_rdy       (imemreq_rdy),
    .imemreq_msg_addr  (imemreq_msg_addr),
    .imemresp_val      (imemresp_val),
    .imemresp_msg_data (imemresp_msg_data),
    .inst_val_Dhl      (inst_val_Dhl),
    .inst_Dhl          (inst_Dhl),
    .pc_Dhl            (pc_Dhl),
    .inst_rdy_Dhl      (inst_rdy_Dhl)
  );

  typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  req_t        mem_q[$];
  ent_t        buf_q[$];
  logic [31:0] delivered[$];
  logic [31:0] m_fpc;
  int          m_epoch;
  int          cyc;
  int          checks;
  int          errors;

  int unsigned rdy_pct, inst_pct, redir_pct, lat_min, lat_max;
  bit          force_redir;
  logic [31:0] force_pc;
  bit          in_reset;
  bit          reset_settled;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic int m_live();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch == m_epoch) n++;
    return n;
  endfunction

  function automatic int m_drop();
    return mem_q.size() - m_live();
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout actual=expired required=event cyc=%0d", name, cyc);
  endtask

  // One clock: drive at negedge, compare #1 later, advance the reference.
  task automatic cycle();
    req_t r;
    bit   exp_val, fire, deq, have_r;
    int   live, drop;
    @(negedge clk);
    reset = in_reset;
    imemreq_rdy  = ($urandom_range(99) < rdy_pct);
    inst_rdy_Dhl = ($urandom_range(99) < inst_pct);
    if (in_reset) begin
      redirect_val      = 1'b0;
      redirect_pc       = $urandom;
      imemresp_val      = 1'b0;
      imemresp_msg_data = $urandom;
    end else begin
      redirect_val = force_redir || ($urandom_range(99) < redir_pct);
      if (force_redir) redirect_pc = force_pc;
      else if ($urandom_range(7) == 0) redirect_pc = 32'hFFFFFFF0 | ($urandom & 32'hC);
      else redirect_pc = $urandom & 32'hFFFFFFFC;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        imemresp_val      = 1'b1;
        imemresp_msg_data = mem_word(mem_q[0].addr);
      end else begin
        imemresp_val      = 1'b0;
        imemresp_msg_data = $urandom;
      end
    end
    #1;
    if (in_reset) begin
      if (reset_settled) begin
        chk1("rst_imemreq_val", imemreq_val, 1'b0);
        chk1("rst_inst_val", inst_val_Dhl, 1'b0);
      end
      mem_q.delete();
      buf_q.delete();
      m_fpc = RV;
    end else begin
      live    = m_live();
      drop    = m_drop();
      exp_val = !redirect_val && (live + buf_q.size() < 2) && (live + drop < 3);
      chk1("imemreq_val", imemreq_val, exp_val);
      chk32("imemreq_addr", imemreq_msg_addr, m_fpc);
      chk1("inst_val", inst_val_Dhl, buf_q.size() != 0);
      if (buf_q.size() != 0) begin
        chk32("pc_Dhl", pc_Dhl, buf_q[0].pc);
        chk32("inst_Dhl", inst_Dhl, buf_q[0].inst);
      end
      fire = exp_val && imemreq_rdy;
      deq  = (buf_q.size() != 0) && inst_rdy_Dhl;
      if (deq) delivered.push_back(buf_q[0].pc);
      have_r = imemresp_val;
      if (have_r) r = mem_q.pop_front();
      if (redirect_val) begin
        buf_q.delete();
        m_fpc = redirect_pc;
        m_epoch++;
      end else begin
        if (deq) void'(buf_q.pop_front());
        if (have_r && r.epoch == m_epoch) buf_q.push_back('{r.addr, mem_word(r.addr)});
        if (fire) begin
          mem_q.push_back('{m_fpc, m_epoch, cyc + int'($urandom_range(lat_max, lat_min))});
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
    @(posedge clk);
    cyc++;
    if (in_reset) reset_settled = 1'b1;
  endtask

  task automatic do_reset(input int n);
    in_reset      = 1'b1;
    reset_settled = 1'b0;
    repeat (n) cycle();
    in_reset = 1'b0;
  endtask

  task automatic pin_delivered(input string name, input int idx, input logic [31:0] exp);
    if (delivered.size() > idx) chk32(name, delivered[idx], exp);
    else timeout_fail(name);
  endtask

  initial begin
    int          n0, prior, i;
    logic [31:0] held;
    bit          ok;
    checks = 0; errors = 0; cyc = 0; m_epoch = 0; m_fpc = RV;
    rdy_pct = 100; inst_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 1;
    force_redir = 1'b0; force_pc = 32'h0;
    reset = 1'b1; redirect_val = 1'b0; redirect_pc = 32'h0; imemreq_rdy = 1'b0;
    imemresp_val = 1'b0; imemresp_msg_data = 32'h0; inst_rdy_Dhl = 1'b0;

    do_reset(3);
    #1 reset = 1'b0;
    #1;
    chk1("post_reset_req_val", imemreq_val, 1'b1);
    chk32("post_reset_addr", imemreq_msg_addr, 32'h00080000);

    // Streaming from the reset vector.
    repeat (12) cycle();
    pin_delivered("stream_pc0", 0, 32'h00080000);
    pin_delivered("stream_pc1", 1, 32'h00080004);
    pin_delivered("stream_pc2", 2, 32'h00080008);

    // Decode stall: buffer fills, requests stop.
    inst_pct = 0;
    repeat (6) cycle();
    #1;
    chk1("stall_req_val", imemreq_val, 1'b0);
    chk1("stall_inst_val", inst_val_Dhl, 1'b1);
    chk32("stall_model_buf", 32'(buf_q.size()), 32'd2);
    inst_pct = 100;
    repeat (10) cycle();
    ok = 1'b1;
    for (int k = 1; k < delivered.size(); k++)
      if (delivered[k] != delivered[k-1] + 32'd4) ok = 1'b0;
    chk1("stall_order_contiguous", ok, 1'b1);

    // Redirect with two requests in flight.
    lat_min = 3; lat_max = 3;
    for (i = 0; i < 30 && m_live() != 2; i++) cycle();
    if (m_live() != 2) timeout_fail("redir2_setup");
    prior = m_live() + m_drop();
    n0 = delivered.size();
    force_redir = 1'b1; force_pc = 32'h00080100;
    cycle();
    force_redir = 1'b0;
    #1;
    chk32("redir2_addr", imemreq_msg_addr, 32'h00080100);
    chk1("redir2_inst_val", inst_val_Dhl, 1'b0);
    chk32("redir2_model_drop", 32'(m_drop()), 32'(prior));
    for (i = 0; i < 40 && delivered.size() <= n0; i++) cycle();
    pin_delivered("redir2_first_pc", n0, 32'h00080100);

    // Redirect coinciding with a response arrival and a dequeue.
    lat_min = 1; lat_max = 1;
    for (i = 0; i < 40 && !(buf_q.size() != 0 && mem_q.size() != 0 && mem_q[0].due <= cyc); i++)
      cycle();
    if (!(buf_q.size() != 0 && mem_q.size() != 0 && mem_q[0].due <= cyc)) timeout_fail("redir_resp_setup");
    prior = m_live() + m_drop();
    force_redir = 1'b1; force_pc = 32'h00090000;
    cycle();
    force_redir = 1'b0;
    #1;
    chk1("redir_resp_inst_val", inst_val_Dhl, 1'b0);
    chk32("redir_resp_model_drop", 32'(m_drop()), 32'(prior - 1));
    repeat (8) cycle();

    // Memory not ready: address holds.
    rdy_pct = 0;
    held = m_fpc;
    repeat (3) cycle();
    #1;
    chk32("rdy_low_addr_held", imemreq_msg_addr, held);

    // Wrap at the top of the address space.
    for (i = 0; i < 20 && mem_q.size() != 0; i++) cycle();
    if (mem_q.size() != 0) timeout_fail("wrap_drain");
    force_redir = 1'b1; force_pc = 32'hFFFFFFFC;
    cycle();
    force_redir = 1'b0;
    #1;
    chk32("wrap_addr_top", imemreq_msg_addr, 32'hFFFFFFFC);
    rdy_pct = 100;
    cycle();
    #1;
    chk32("wrap_addr_zero", imemreq_msg_addr, 32'h00000000);
    repeat (6) cycle();

    // Randomized phases, with a mid-run reset.
    rdy_pct = 70; inst_pct = 60; redir_pct = 5; lat_min = 1; lat_max = 4;
    repeat (2500) cycle();
    do_reset(2);
    rdy_pct = 90; inst_pct = 90; redir_pct = 2; lat_max = 2;
    repeat (1500) cycle();
    rdy_pct = 50; inst_pct = 30; redir_pct = 15; lat_max = 4;
    repeat (1000) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
